// File: rtl/image_buffer.sv
// Byte-addressed image store: SPI-side byte writes with fill counting,
// zero-wipe on clear, and a registered MSB-first 1-bit pixel read port.
module image_buffer #(
  parameter int unsigned IMG_BYTES = 113,
  parameter int unsigned IMG_BITS  = 900,
  parameter int unsigned PIX_AW    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              buffer_write_request,
  output logic              buffer_write_ready,
  input  logic [7:0]        buffer_write_data,
  input  logic [6:0]        buffer_write_addr,
  output logic              buffer_full,
  output logic              buffer_empty,
  input  logic              pix_rd_en,
  input  logic [PIX_AW-1:0] pix_rd_addr,
  output logic              pix_rd_data,
  output logic              pix_rd_valid,
  output logic              wr_error
);

  typedef enum logic [1:0] {WIPE, READY, FULL} state_t;

  localparam int unsigned LAST_IDX = IMG_BYTES - 1;
  localparam logic [6:0]        LAST_BYTE = LAST_IDX[6:0];
  localparam logic [7:0]        CNT_LAST  = LAST_IDX[7:0];
  localparam logic [7:0]        CNT_LIMIT = IMG_BYTES[7:0];
  localparam logic [PIX_AW:0]   PIX_LIMIT = IMG_BITS[PIX_AW:0];

  state_t     state;
  logic [6:0] wipe_ptr;
  logic [7:0] wr_count;
  logic [7:0] mem [0:127];

  logic       addr_ok;
  logic       accept;
  logic       mem_we;
  logic [6:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       pix_in_range;
  logic [6:0] rd_byte;
  logic [2:0] rd_bit;

  assign addr_ok      = {1'b0, buffer_write_addr} < CNT_LIMIT;
  assign accept       = (state == READY) && buffer_write_request && addr_ok && !clear;
  assign mem_we       = !rst && ((state == WIPE) || accept);
  assign mem_waddr    = (state == WIPE) ? wipe_ptr : buffer_write_addr;
  assign mem_wdata    = (state == WIPE) ? '0 : buffer_write_data;
  assign pix_in_range = {1'b0, pix_rd_addr} < PIX_LIMIT;
  assign rd_byte      = 7'(pix_rd_addr >> 3);
  // Pixel 0 sits in bit 7 of byte 0, so the bit index is the inverted low bits.
  assign rd_bit       = ~pix_rd_addr[2:0];

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_rd_valid <= 1'b0;
      pix_rd_data  <= 1'b0;
    end else begin
      pix_rd_valid <= pix_rd_en;
      pix_rd_data  <= (pix_rd_en && (state != WIPE) && pix_in_range) ?
                      mem[rd_byte][rd_bit] : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= WIPE;
      wipe_ptr           <= '0;
      wr_count           <= '0;
      buffer_full        <= 1'b0;
      buffer_empty       <= 1'b0;
      buffer_write_ready <= 1'b0;
      wr_error           <= 1'b0;
    end else begin
      case (state)
        WIPE: begin
          wipe_ptr <= wipe_ptr + 7'd1;
          if (wipe_ptr == LAST_BYTE) begin
            state              <= READY;
            buffer_empty       <= 1'b1;
            buffer_write_ready <= 1'b1;
          end
        end
        READY: begin
          // An already-clean buffer ignores a held clear so the FSM can wait on buffer_empty.
          if (clear) begin
            if (!buffer_empty) begin
              state              <= WIPE;
              wipe_ptr           <= '0;
              wr_count           <= '0;
              buffer_full        <= 1'b0;
              buffer_write_ready <= 1'b0;
              wr_error           <= 1'b0;
            end
          end else if (buffer_write_request) begin
            if (addr_ok) begin
              wr_count     <= wr_count + 8'd1;
              buffer_empty <= 1'b0;
              if (wr_count == CNT_LAST) begin
                state              <= FULL;
                buffer_full        <= 1'b1;
                buffer_write_ready <= 1'b0;
              end
            end else begin
              wr_error <= 1'b1;
            end
          end
        end
        FULL: begin
          if (clear) begin
            state              <= WIPE;
            wipe_ptr           <= '0;
            wr_count           <= '0;
            buffer_full        <= 1'b0;
            buffer_write_ready <= 1'b0;
            wr_error           <= 1'b0;
          end else if (buffer_write_request) begin
            wr_error <= 1'b1;
          end
        end
        default: begin
          state              <= WIPE;
          wipe_ptr           <= '0;
          buffer_write_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/image_buffer.md
Name: image_buffer

Overview:
- Byte-addressed image store between the SPI controller FSM (write side) and the BNN core (read side).
- Accepts image bytes over a request/ready handshake and counts them.
- Raises buffer_full once a complete image has been received.
- Wipes its contents to zero on clear and exposes a registered 1-bit pixel read port to the BNN.

Parameters:
- IMG_BYTES, 113: bytes per image; buffer_full asserts after this many accepted writes; must be ≤ 128.
- IMG_BITS, 900: valid pixels; IMG_BITS ≤ 8*IMG_BYTES; trailing padding bits are never readable.
- PIX_AW, 10: pixel read address width; must satisfy 2^PIX_AW ≥ IMG_BITS.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- clear  in  1  level; request wipe of buffer
- buffer_write_request  in  1  write strobe from FSM
- buffer_write_ready  out  1  buffer can accept a write this cycle
- buffer_write_data  in  8  image byte, MSB = lowest pixel index
- buffer_write_addr  in  7  byte address
- buffer_full  out  1  IMG_BYTES bytes accepted
- buffer_empty  out  1  wipe complete, no byte written since
- pix_rd_en  in  1  BNN pixel read request
- pix_rd_addr  in  PIX_AW  pixel index 0..IMG_BITS-1
- pix_rd_data  out  1  pixel value
- pix_rd_valid  out  1  pix_rd_data valid this cycle
- wr_error  out  1  sticky: write dropped (full, or address ≥ IMG_BYTES)

Behaviour:
- States: WIPE, READY, FULL.
- Reset (rst=1 at posedge):
  - state=WIPE, wipe_ptr=0, wr_count=0.
  - All outputs 0: buffer_full, buffer_empty, buffer_write_ready, pix_rd_data, pix_rd_valid, wr_error.
  - Reset mid-image or mid-wipe behaves identically.
- WIPE:
  - Writes 8'h00 to mem[wipe_ptr] each cycle and increments wipe_ptr.
  - When wipe_ptr == IMG_BYTES-1 the next state is READY and buffer_empty is set to 1 (registered). Total wipe = IMG_BYTES cycles.
  - buffer_write_ready=0; incoming requests are ignored and do not set wr_error.
  - clear is ignored while in WIPE.
- READY:
  - buffer_write_ready=1.
  - Accepted write = buffer_write_request && buffer_write_ready && addr < IMG_BYTES && !clear.
    - Stores data at addr, wr_count += 1, buffer_empty := 0.
  - A request with addr ≥ IMG_BYTES is dropped and sets wr_error.
  - When an accepted write makes wr_count == IMG_BYTES: next state FULL, buffer_full=1 the following cycle (1-cycle latency from the accepting edge).
  - wr_count counts accepted writes, not distinct addresses. A repeated address overwrites the byte and still counts.
- FULL:
  - buffer_full=1, buffer_write_ready=0.
  - Any buffer_write_request sets wr_error; memory and count are unchanged.
- clear:
  - In READY or FULL with buffer_empty=0: next state WIPE, wipe_ptr=0, wr_count=0, buffer_full=0, wr_error=0.
  - In READY with buffer_empty=1 (already clean): no action. This lets the FSM hold clear high until buffer_empty without retriggering.
  - Same-cycle clear and write: clear wins, the write is dropped and wr_error is not set.
- Pixel read:
  - pix_rd_en at edge N gives pix_rd_valid=1 and pix_rd_data at edge N+1 (1-cycle latency). Fully pipelined, one read per cycle.
  - Byte = pix_rd_addr >> 3; bit = 7 - (pix_rd_addr & 7), i.e. MSB-first.
  - Reads in WIPE state, or with pix_rd_addr ≥ IMG_BITS, return 0 with valid=1.
  - Reads during FULL/READY see the current memory. Read and write to the same byte in the same cycle return the old value.
- buffer_empty is registered; it is 0 from reset until the first wipe completes.
- wr_error is cleared only by rst or by starting a wipe.

Test Plan:
- Reset, then idle → empty=0 and ready=0 for 113 cycles; empty=1 and ready=1 on cycle 114; pixel reads all return 0.
- Write bytes 0x00..0x70 to addr 0..112 in consecutive cycles → full=1 one cycle after the write to addr 112, ready=0.
  - Pixel 8 (byte 1 = 0x01) reads 0; pixel 15 reads 1; each read lands one cycle after en.
- While FULL, request a write of 0xAA to addr 5 → wr_error=1 and byte 5 unchanged (pixels 40..47 still read 0x05 pattern).
- After 50 writes, hold clear high for 200 cycles → full=0, empty=1 exactly 113 cycles after clear, no second wipe, all pixels 0.
- Write of 0xFF with addr=120 → dropped, wr_error=1, wr_count unchanged. Same-cycle clear plus write to addr 0 → write dropped, wipe starts, wr_error=0.
- Assert rst for 1 cycle mid-image after 60 writes → all outputs 0, then a fresh 113-cycle wipe; full only after 113 new writes.
